conv_frame_sequencer: RTL and testbench



---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_mac9.sv | 64 ++++++
 rtl/conv_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer and its MAC.
// Optional feature macro: CONV_ABS_EN (absolute-value rectification in conv_mac9).
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_FETCH,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int COEFW = 8;

    function automatic int clamp_limit(input int bitw);
        return (1 << bitw) - 1;
    endfunction

endpackage

// File: rtl/conv_mac9.sv
// Signed 3x3 multiply-accumulate with rectify/clamp of the final sum.
// CONV_ABS_EN defined: |acc| clamped; undefined: negatives forced to zero, then clamped.
module conv_mac9
    import conv_pkg::*;
#(
    parameter int BITW = 8,
    parameter int ACCW = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             mac_en,
    input  logic             finish,
    input  logic             zero,
    input  logic [BITW-1:0]  pixel,
    input  logic [COEFW-1:0] coef,
    output logic [BITW-1:0]  result
);

    localparam logic signed [ACCW-1:0] LIMIT = ACCW'(clamp_limit(BITW));

    logic signed [ACCW-1:0]       acc;
    logic signed [ACCW-1:0]       sum;
    logic signed [BITW:0]         px;
    logic signed [COEFW-1:0]      c;
    logic signed [BITW+COEFW:0]   prod;

    function automatic logic [BITW-1:0] rectify(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] m;
`ifdef CONV_ABS_EN
        m = (a < 0) ? -a : a;
`else
        m = (a < 0) ? '0 : a;
`endif
        return (m > LIMIT) ? LIMIT[BITW-1:0] : m[BITW-1:0];
    endfunction

    always_comb begin
        px   = signed'({1'b0, pixel});
        c    = signed'(coef);
        prod = px * c;
        sum  = acc + ACCW'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= sum;
            end
            // The last tap arrives in the same cycle the result is taken, so fold it in here.
            if (zero) begin
                result <= '0;
            end else if (finish) begin
                result <= rectify(mac_en ? sum : acc);
            end
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 convolution: FSM, raster counters, window address
// generation and output stream. CONV_ABS_EN selects the rectify mode in conv_mac9.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int BITW   = 8,
    parameter int ACCW   = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [9*COEFW-1:0]                kernel,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_rd_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   mem_addr,
    input  logic [BITW-1:0]                   mem_rd_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BITW-1:0]                   out_data,
    output logic [$clog2(WIDTH)-1:0]          out_x,
    output logic [$clog2(HEIGHT)-1:0]         out_y
);

    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    state_t             state_q, state_d;
    logic [XW-1:0]      col;
    logic [YW-1:0]      row;
    logic [3:0]         tap, tap_d;
    logic [1:0]         tap_r, tap_c;
    logic               rd_d;
    logic [9*COEFW-1:0] kernel_q;
    logic [COEFW-1:0]   coef;
    logic               border, last_pixel;
    logic               mac_clear, mac_zero, mac_finish;

    assign border     = (row == '0) || (row == YW'(HEIGHT-1)) ||
                        (col == '0) || (col == XW'(WIDTH-1));
    assign last_pixel = (row == YW'(HEIGHT-1)) && (col == XW'(WIDTH-1));
    assign coef       = kernel_q[32'(tap_d)*COEFW +: COEFW];
    assign out_x      = col;
    assign out_y      = row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        done       = 1'b0;
        out_valid  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        mac_clear  = 1'b0;
        mac_zero   = 1'b0;
        mac_finish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = ST_CLASSIFY;
                    mac_clear = 1'b1;
                end
            end
            ST_CLASSIFY: begin
                if (border) begin
                    mac_zero = 1'b1;
                    state_d  = ST_EMIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd_en = 1'b1;
                // Window tap (tap_r, tap_c) relative to the centre pixel, offset by -1 each way.
                mem_addr  = AW'((32'(row) + 32'(tap_r) - 32'd1) * 32'(WIDTH) +
                                32'(col) + 32'(tap_c) - 32'd1);
                if (tap == 4'd8) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mac_finish = 1'b1;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    mac_clear = 1'b1;
                    state_d   = last_pixel ? ST_DONE : ST_CLASSIFY;
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            tap      <= '0;
            tap_r    <= '0;
            tap_c    <= '0;
            tap_d    <= '0;
            rd_d     <= 1'b0;
            kernel_q <= '0;
        end else begin
            rd_d  <= (state_q == ST_FETCH);
            tap_d <= tap;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        kernel_q <= kernel;
                        row      <= '0;
                        col      <= '0;
                    end
                end
                ST_CLASSIFY: begin
                    tap   <= '0;
                    tap_r <= '0;
                    tap_c <= '0;
                end
                ST_FETCH: begin
                    tap <= (tap == 4'd8) ? 4'd0 : tap + 4'd1;
                    if (tap_c == 2'd2) begin
                        tap_c <= '0;
                        tap_r <= tap_r + 2'd1;
                    end else begin
                        tap_c <= tap_c + 2'd1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (col == XW'(WIDTH-1)) begin
                            col <= '0;
                            row <= (row == YW'(HEIGHT-1)) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    conv_mac9 #(
        .BITW (BITW),
        .ACCW (ACCW)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .mac_en (rd_d),
        .finish (mac_finish),
        .zero   (mac_zero),
        .pixel  (mem_rd_data),
        .coef   (coef),
        .result (out_data)
    );

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed self-checking bench for conv_frame_sequencer on an 8x8 image with a Sobel-X kernel.
// Expectations for the descending ramp follow CONV_ABS_EN.
module tb_conv_frame_sequencer;

    localparam logic [71:0] SOBEL = {8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [71:0] kernel;
    logic        busy, done, mem_rd_en, out_valid, out_ready;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  out_data;
    logic [2:0]  out_x, out_y;

    logic [7:0]  img [64];

    logic [7:0]  got_d [64];
    logic [2:0]  got_x [64];
    logic [2:0]  got_y [64];
    int          got_t [64];
    logic [5:0]  rd_addr [9];
    int          n_out, done_cnt, stall_viol, read_viol, rd_count;
    bit          timed_out, busy_at_done;

    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= img[mem_addr];
    end

    conv_frame_sequencer #(
        .WIDTH  (8),
        .HEIGHT (8),
        .BITW   (8),
        .ACCW   (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kernel      (kernel),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y)
    );

    function automatic bit is_border(input int x, input int y);
        return (x == 0) || (x == 7) || (y == 0) || (y == 7);
    endfunction

    // Drives one frame and records every handshake, read strobe and stall observation.
    task automatic run_frame(input bit rand_ready, input bit mid_start);
        int         cyc_n, after;
        bit         held;
        logic [7:0] hd;
        logic [2:0] hx, hy;
        n_out = 0; done_cnt = 0; stall_viol = 0; read_viol = 0; rd_count = 0;
        timed_out = 0; busy_at_done = 0;
        for (int i = 0; i < 64; i++) begin
            got_d[i] = 'x; got_x[i] = 'x; got_y[i] = 'x; got_t[i] = -1;
        end
        for (int i = 0; i < 9; i++) rd_addr[i] = 'x;
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc_n = 0; after = -1; held = 0; hd = '0; hx = '0; hy = '0;
        while (1) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mid_start) begin
                start  = (cyc_n == 40);
                kernel = (cyc_n == 40) ? '0 : SOBEL;
            end
            if (held && (!out_valid || out_data !== hd || out_x !== hx || out_y !== hy))
                stall_viol++;
            held = out_valid && !out_ready;
            hd = out_data; hx = out_x; hy = out_y;
            if (out_valid && !out_ready && mem_rd_en) read_viol++;
            if (mem_rd_en) begin
                if (rd_count < 9) rd_addr[rd_count] = mem_addr;
                rd_count++;
            end
            if (out_valid && out_ready && n_out < 64) begin
                got_d[n_out] = out_data; got_x[n_out] = out_x;
                got_y[n_out] = out_y;    got_t[n_out] = cyc_n;
                n_out++;
            end
            if (done) begin
                done_cnt++;
                if (busy) busy_at_done = 1;
            end
            if (done && after < 0) after = 4;
            else if (after > 0) after--;
            if (after == 0) break;
            cyc_n++;
            if (cyc_n > 4000) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b1; kernel = SOBEL;
    endtask

    task automatic check_frame_basic(input string name);
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_fail++; $display("FAIL %s_timeout: frame did not finish within 4000 cycles", name);
        end
        n_checks++;
        if (n_out !== 64) begin
            n_fail++; $display("FAIL %s_count: got %0d outputs, expected 64", name, n_out);
        end
        n_checks++;
        if (done_cnt !== 1 || busy_at_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done pulses %0d busy_at_done %0b busy_after %0b, expected 1 0 0",
                     name, done_cnt, busy_at_done, busy);
        end
        n_checks++;
        if (rd_count !== 324) begin
            n_fail++; $display("FAIL %s_reads: %0d read strobes, expected 324", name, rd_count);
        end
    endtask

    task automatic check_ramp_outputs(input string name, input logic [7:0] interior);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e;
            e = is_border(i % 8, i / 8) ? 8'd0 : interior;
            n_checks++;
            if (got_d[i] !== e || got_x[i] !== 3'(i % 8) || got_y[i] !== 3'(i / 8)) begin
                n_fail++;
                $display("FAIL %s_pix%0d: got data %0d x %0d y %0d, expected data %0d x %0d y %0d",
                         name, i, got_d[i], got_x[i], got_y[i], e, i % 8, i / 8);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; kernel = SOBEL;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", mem_rd_en); end
        n_checks++; if (mem_addr !== 6'd0)  begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
        n_checks++; if (out_data !== 8'd0)  begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        n_checks++; if (out_x !== 3'd0)     begin n_fail++; $display("FAIL reset_x: got %0d expected 0", out_x); end
        n_checks++; if (out_y !== 3'd0)     begin n_fail++; $display("FAIL reset_y: got %0d expected 0", out_y); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_constant();
        for (int i = 0; i < 64; i++) img[i] = 8'd100;
        run_frame(0, 0);
        check_frame_basic("const");
        check_ramp_outputs("const", 8'd0);
        for (int i = 0; i < 9; i++) begin
            logic [5:0] e;
            e = 6'((i / 3) * 8 + (i % 3));
            n_checks++;
            if (rd_addr[i] !== e) begin
                n_fail++; $display("FAIL const_addr%0d: got %0d expected %0d", i, rd_addr[i], e);
            end
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 64; i++) img[i] = 8'(10 * (i % 8));
        run_frame(0, 0);
        check_frame_basic("ramp");
        check_ramp_outputs("ramp", 8'd80);
        n_checks++;
        if (got_t[0] !== 1 || got_t[1] - got_t[0] !== 2) begin
            n_fail++; $display("FAIL ramp_border_latency: got t0 %0d gap %0d, expected 1 and 2",
                               got_t[0], got_t[1] - got_t[0]);
        end
        n_checks++;
        if (got_t[9] - got_t[8] !== 12) begin
            n_fail++; $display("FAIL ramp_interior_latency: got gap %0d expected 12", got_t[9] - got_t[8]);
        end
    endtask

    task automatic test_descending();
        for (int i = 0; i < 64; i++) img[i] = 8'(200 - 10 * (i % 8));
        run_frame(0, 0);
        check_frame_basic("desc");
`ifdef CONV_ABS_EN
        check_ramp_outputs("desc", 8'd80);
`else
        check_ramp_outputs("desc", 8'd0);
`endif
    endtask

    task automatic test_checker();
        for (int i = 0; i < 64; i++) img[i] = ((((i % 8) / 2) + ((i / 8) / 2)) % 2 == 1) ? 8'd255 : 8'd0;
        run_frame(0, 0);
        check_frame_basic("chk");
        n_checks++;
        if (got_d[9] !== 8'd255) begin
            n_fail++; $display("FAIL chk_clamp_pos: pixel (1,1) got %0d expected 255", got_d[9]);
        end
        n_checks++;
`ifdef CONV_ABS_EN
        if (got_d[18] !== 8'd255) begin
            n_fail++; $display("FAIL chk_clamp_neg: pixel (2,2) got %0d expected 255", got_d[18]);
        end
`else
        if (got_d[18] !== 8'd0) begin
            n_fail++; $display("FAIL chk_clamp_neg: pixel (2,2) got %0d expected 0", got_d[18]);
        end
`endif
        n_checks++;
        if (got_d[0] !== 8'd0 || got_d[7] !== 8'd0 || got_d[56] !== 8'd0 || got_d[63] !== 8'd0) begin
            n_fail++; $display("FAIL chk_border: corners got %0d %0d %0d %0d expected 0",
                               got_d[0], got_d[7], got_d[56], got_d[63]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) img[i] = 8'(10 * (i % 8));
        run_frame(1, 1);
        check_frame_basic("bp");
        check_ramp_outputs("bp", 8'd80);
        n_checks++;
        if (stall_viol !== 0) begin
            n_fail++; $display("FAIL bp_stable: %0d stall cycles changed outputs, expected 0", stall_viol);
        end
        n_checks++;
        if (read_viol !== 0) begin
            n_fail++; $display("FAIL bp_no_reads: %0d reads during stalls, expected 0", read_viol);
        end
    endtask

    task automatic test_reset_midframe();
        int seen, cyc;
        for (int i = 0; i < 64; i++) img[i] = 8'(10 * (i % 8));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 12 && cyc < 300) begin
            if (mem_rd_en) seen++;
            if (seen < 12) begin
                @(negedge clk); cyc++;
            end
        end
        n_checks++;
        if (seen !== 12) begin
            n_fail++; $display("FAIL midrst_reach_fetch: saw %0d reads, expected 12", seen);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || mem_rd_en !== 1'b0 ||
            mem_addr !== 6'd0 || out_data !== 8'd0 || out_x !== 3'd0 || out_y !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy %0b done %0b valid %0b rd %0b addr %0d data %0d x %0d y %0d, expected all 0",
                     busy, done, out_valid, mem_rd_en, mem_addr, out_data, out_x, out_y);
        end
        rst = 1'b0;
        @(negedge clk);
        run_frame(0, 0);
        check_frame_basic("midrst");
        check_ramp_outputs("midrst", 8'd80);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_descending();
        test_checker();
        test_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
